// File: rtl/superio_reg_file_if.sv
// superio_reg_file_if
//   Bundles the two buses that meet at the SuperIO register file:
//   - HPS side (sel, write, read, writedata, readdata, readdatavalid): one-hot
//     selects from the address decoder plus the QSYS slave strobes and data.
//   - Card side (bus_req, bus_rw, bus_addr, bus_wdata, bus_ack, bus_rdata):
//     single-byte request/acknowledge transactions toward the CT2960 card bus.
//   - irq: interrupt level back to the HPS.
//   Modports:
//     slave  - view of the register file itself
//     master - view of whatever drives the HPS strobes and answers the card bus
//   Parameters: DATA_W (card data width), ADDR_W (card address width).
interface superio_reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic [5:0]        sel;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              bus_req;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              irq;

  modport slave (
    input  sel, write, read, writedata, bus_ack, bus_rdata,
    output readdata, readdatavalid, bus_req, bus_rw, bus_addr, bus_wdata, irq
  );

  modport master (
    output sel, write, read, writedata, bus_ack, bus_rdata,
    input  readdata, readdatavalid, bus_req, bus_rw, bus_addr, bus_wdata, irq
  );
endinterface

// File: rtl/superio_reg_file.sv
// superio_reg_file
//   Register file and card-transaction engine behind the SuperIO decoder.
//   The HPS loads an address register, a data register and a control
//   register; writing GO launches one single-byte read or write on the card
//   bus. Card read data and transaction status are kept for HPS read-back.
//
//   Register map (one-hot sel):
//     6'h01 ctrl wr   : bit0 GO (self-clearing), bit1 RW, bit2 IRQ_ENA, bit7 CLR
//     6'h02 status rd : {28'b0, SEL_ERR, TIMEOUT, DONE, BUSY}
//     6'h04 addr wr   : writedata[ADDR_W-1:0]
//     6'h08 data wr   : writedata[DATA_W-1:0]
//     6'h10 card rd   : zero-extended card data register
//
//   Ports:
//     clk   - rising-edge clock for every register
//     reset - synchronous, active-high
//     bus   - superio_reg_file_if.slave (HPS strobes, card bus, irq)
//
//   Parameters: DATA_W, ADDR_W, TIMEOUT_CYCLES (WAIT cycles without ack
//   before the transaction is abandoned; must be >= 2).
//
//   Optional feature: define SUPERIO_REGFILE_IRQ_EN to drive irq as the
//   registered level IRQ_ENA & (DONE | TIMEOUT). Without it irq is tied low
//   and IRQ_ENA is stored but has no effect.
module superio_reg_file #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              reset,
  superio_reg_file_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              busReq_q;
  logic              busRw_q;
  logic [DATA_W-1:0] cardData_q;

  logic              ctrlRw_q,  ctrlRw_d;
  logic              irqEna_q,  irqEna_d;
  logic              done_q,    done_d;
  logic              timeout_q, timeout_d;
  logic              selErr_q,  selErr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       readData_q, readData_d;
  logic              readValid_q;

  logic selAny, selOneHot, selErrEvt;
  logic ctrlWr, addrWr, dataWr, clrReq, goReq;
  logic ackHit, tmoHit;

  // Decode the strobes. A select with more than one bit set is an error:
  // nothing is written, reads return 0, and SEL_ERR latches. Address/data
  // loads are refused while a transaction is in flight so the card bus sees
  // stable values.
  always_comb begin
    selAny    = |bus.sel;
    selOneHot = selAny && ((bus.sel & (bus.sel - 6'd1)) == 6'd0);
    selErrEvt = selAny && !selOneHot && (bus.write || bus.read);
    ctrlWr    = bus.write && selOneHot && bus.sel[0];
    addrWr    = bus.write && selOneHot && bus.sel[2] && !busy_q;
    dataWr    = bus.write && selOneHot && bus.sel[3] && !busy_q;
    clrReq    = ctrlWr && bus.writedata[7];
    goReq     = ctrlWr && bus.writedata[0] && !busy_q;
    ackHit    = (state_q == ST_WAIT) && bus.bus_ack;
    tmoHit    = (state_q == ST_WAIT) && !bus.bus_ack && (cnt_q == CNT_LAST);
  end

  // Next-state of the control and status bits. CLR is applied first so that
  // a completion arriving in the same cycle is still recorded; ack beats
  // timeout because tmoHit already excludes a cycle with bus_ack.
  always_comb begin
    ctrlRw_d  = ctrlWr ? bus.writedata[1] : ctrlRw_q;
    irqEna_d  = ctrlWr ? bus.writedata[2] : irqEna_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    selErr_d  = selErr_q;
    if (clrReq) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
      selErr_d  = 1'b0;
    end
    if (ackHit || tmoHit) begin
      done_d = 1'b1;
    end
    if (tmoHit) begin
      timeout_d = 1'b1;
    end
    if (selErrEvt) begin
      selErr_d = 1'b1;
    end
  end

  // Read mux. Only exact one-hot selects of readable registers return
  // data; anything else reads as 0 but is still acknowledged.
  always_comb begin
    readData_d = 32'd0;
    case (bus.sel)
      6'h02:   readData_d = {28'd0, selErr_q, timeout_q, done_q, busy_q};
      6'h10:   readData_d = 32'(cardData_q);
      default: readData_d = 32'd0;
    endcase
  end

  // Transaction FSM. GO is honoured in IDLE and in the one-cycle DONE state
  // (BUSY is already low there). bus_req rises with the move to REQ and is
  // held until ack or timeout. Card read data is captured on the ack edge
  // only for read transactions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      busReq_q   <= 1'b0;
      busRw_q    <= 1'b0;
      cardData_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (goReq) begin
            state_q  <= ST_REQ;
            busy_q   <= 1'b1;
            busReq_q <= 1'b1;
            busRw_q  <= ctrlRw_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          if (ackHit || tmoHit) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            busReq_q <= 1'b0;
            if (ackHit && !busRw_q) begin
              cardData_q <= bus.bus_rdata;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // HPS-visible registers: control bits, sticky status flags and the
  // address/data registers that feed the card bus directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlRw_q  <= 1'b0;
      irqEna_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      selErr_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      ctrlRw_q  <= ctrlRw_d;
      irqEna_q  <= irqEna_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      selErr_q  <= selErr_d;
      if (addrWr) begin
        addr_q <= bus.writedata[ADDR_W-1:0];
      end
      if (dataWr) begin
        data_q <= bus.writedata[DATA_W-1:0];
      end
    end
  end

  // Registered read return: data and valid appear one clock after the read
  // strobe. Reads sample the pre-edge register values, so a read issued with
  // a write in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q  <= 32'd0;
      readValid_q <= 1'b0;
    end else begin
      readValid_q <= bus.read && selAny;
      readData_q  <= (bus.read && selAny) ? readData_d : 32'd0;
    end
  end

`ifdef SUPERIO_REGFILE_IRQ_EN
  logic irq_q;

  // Interrupt level built from next-state values so it moves on the same
  // edge as DONE/TIMEOUT/IRQ_ENA rather than one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irqEna_d & (done_d | timeout_d);
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.readdata      = readData_q;
  assign bus.readdatavalid = readValid_q;
  assign bus.bus_req       = busReq_q;
  assign bus.bus_rw        = busRw_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_wdata     = data_q;

endmodule

// File: tb/tb_superio_reg_file.sv
// tb_superio_reg_file
//   Directed bench for superio_reg_file with TIMEOUT_CYCLES=16. Every HPS
//   read pushes its expected data and return cycle onto a queue; a monitor
//   on the falling edge pops and compares whenever readdatavalid is high.
//   Card-bus outputs and irq are compared directly after each step.
module tb_superio_reg_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int TMO    = 16;

`ifdef SUPERIO_REGFILE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  superio_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  superio_reg_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } rdExp_t;

  rdExp_t expQ[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Cycle counter used to confirm the one-clock read latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one HPS cycle; called at posedge+1, returns at the next posedge+1.
  task automatic applyStimulus(input logic [5:0] sel, input logic wr, input logic rd,
                               input logic [31:0] wdata);
    bus.sel       = sel;
    bus.write     = wr;
    bus.read      = rd;
    bus.writedata = wdata;
    @(posedge clk);
    #1;
    bus.sel       = 6'h00;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.writedata = 32'd0;
  endtask

  task automatic hpsWrite(input logic [5:0] sel, input logic [31:0] wdata);
    applyStimulus(sel, 1'b1, 1'b0, wdata);
  endtask

  task automatic hpsRead(input logic [5:0] sel, input logic [31:0] exp);
    rdExp_t e;
    e.data  = exp;
    e.cycle = cyc + 1;
    expQ.push_back(e);
    applyStimulus(sel, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cardAck(input logic [7:0] rdata);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = rdata;
    idle(1);
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 8'hFF;
  endtask

  // Scoreboard monitor: every readdatavalid must match the oldest queued read.
  always @(negedge clk) begin : monitor
    rdExp_t e;
    if (bus.readdatavalid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedValid: got readdata 0x%0h, expected no response", bus.readdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("readdata", bus.readdata, e.data);
        checkOutput("readLatency", cyc, e.cycle);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.sel       = 6'h00;
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.writedata = 32'd0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 8'hFF;
    reset         = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstBusReq", 32'(bus.bus_req), 32'd0);
    checkOutput("rstBusRw", 32'(bus.bus_rw), 32'd0);
    checkOutput("rstBusAddr", 32'(bus.bus_addr), 32'd0);
    checkOutput("rstBusWdata", 32'(bus.bus_wdata), 32'd0);
    checkOutput("rstIrq", 32'(bus.irq), 32'd0);
    checkOutput("rstValid", 32'(bus.readdatavalid), 32'd0);
    checkOutput("rstReaddata", bus.readdata, 32'd0);
    hpsRead(6'h02, 32'h0);

    $display("[TB] card write with busy guards");
    hpsWrite(6'h04, 32'h0000_0220);
    hpsWrite(6'h08, 32'h0000_00A5);
    hpsWrite(6'h01, 32'h0000_0003);
    checkOutput("wrBusReq", 32'(bus.bus_req), 32'd1);
    checkOutput("wrBusRw", 32'(bus.bus_rw), 32'd1);
    checkOutput("wrBusAddr", 32'(bus.bus_addr), 32'h0220);
    checkOutput("wrBusWdata", 32'(bus.bus_wdata), 32'hA5);
    hpsRead(6'h02, 32'h1);
    hpsWrite(6'h04, 32'h0000_1234);
    hpsWrite(6'h08, 32'h0000_005A);
    hpsWrite(6'h01, 32'h0000_0001);
    checkOutput("busyAddrHeld", 32'(bus.bus_addr), 32'h0220);
    checkOutput("busyWdataHeld", 32'(bus.bus_wdata), 32'hA5);
    checkOutput("busyRwHeld", 32'(bus.bus_rw), 32'd1);
    checkOutput("busyReqHeld", 32'(bus.bus_req), 32'd1);
    cardAck(8'h99);
    checkOutput("wrReqDrop", 32'(bus.bus_req), 32'd0);
    hpsRead(6'h02, 32'h2);
    hpsRead(6'h10, 32'h0);

    $display("[TB] ack outside WAIT");
    bus.bus_ack = 1'b1;
    idle(2);
    bus.bus_ack = 1'b0;
    checkOutput("strayAckReq", 32'(bus.bus_req), 32'd0);
    hpsRead(6'h02, 32'h2);

    $display("[TB] card read with CLR+GO");
    hpsWrite(6'h01, 32'h0000_0081);
    checkOutput("rdBusRw", 32'(bus.bus_rw), 32'd0);
    checkOutput("rdBusReq", 32'(bus.bus_req), 32'd1);
    hpsRead(6'h02, 32'h1);
    cardAck(8'h3C);
    hpsRead(6'h10, 32'h3C);
    hpsRead(6'h02, 32'h2);

    $display("[TB] timeout");
    hpsWrite(6'h01, 32'h0000_0081);
    n = 0;
    while (bus.bus_req === 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    checkOutput("tmoReqCycles", 32'(n), 32'd17);
    hpsRead(6'h02, 32'h6);
    hpsRead(6'h10, 32'h3C);

    $display("[TB] ack on final WAIT cycle");
    hpsWrite(6'h01, 32'h0000_0081);
    idle(16);
    checkOutput("lastCycleReq", 32'(bus.bus_req), 32'd1);
    cardAck(8'h5A);
    checkOutput("lastAckReqDrop", 32'(bus.bus_req), 32'd0);
    hpsRead(6'h02, 32'h2);
    hpsRead(6'h10, 32'h5A);

    $display("[TB] select guards");
    hpsWrite(6'h11, 32'h0000_00FF);
    checkOutput("badSelNoGo", 32'(bus.bus_req), 32'd0);
    hpsRead(6'h02, 32'hA);
    hpsRead(6'h11, 32'h0);
    hpsRead(6'h01, 32'h0);
    applyStimulus(6'h00, 1'b0, 1'b1, 32'd0);
    applyStimulus(6'h00, 1'b1, 1'b0, 32'h0000_0001);
    checkOutput("selZeroNoGo", 32'(bus.bus_req), 32'd0);
    hpsWrite(6'h0C, 32'h0000_BEEF);
    checkOutput("badSelAddr", 32'(bus.bus_addr), 32'h0220);
    checkOutput("badSelWdata", 32'(bus.bus_wdata), 32'hA5);
    hpsWrite(6'h01, 32'h0000_0080);
    hpsRead(6'h02, 32'h0);
    hpsWrite(6'h08, 32'h0000_01C3);
    checkOutput("dataTrunc", 32'(bus.bus_wdata), 32'hC3);

    $display("[TB] irq");
    hpsWrite(6'h01, 32'h0000_0005);
    checkOutput("irqBusy", 32'(bus.irq), 32'd0);
    idle(1);
    cardAck(8'h77);
    checkOutput("irqDone", 32'(bus.irq), 32'(IRQ_ON));
    hpsRead(6'h02, 32'h2);
    hpsRead(6'h10, 32'h77);
    hpsWrite(6'h01, 32'h0000_0080);
    checkOutput("irqClr", 32'(bus.irq), 32'd0);

    $display("[TB] reset mid-WAIT");
    hpsWrite(6'h01, 32'h0000_0003);
    idle(1);
    reset = 1'b1;
    idle(1);
    checkOutput("midRstReq", 32'(bus.bus_req), 32'd0);
    idle(1);
    reset = 1'b0;
    checkOutput("midRstRw", 32'(bus.bus_rw), 32'd0);
    checkOutput("midRstAddr", 32'(bus.bus_addr), 32'd0);
    checkOutput("midRstWdata", 32'(bus.bus_wdata), 32'd0);
    checkOutput("midRstIrq", 32'(bus.irq), 32'd0);
    hpsRead(6'h02, 32'h0);
    hpsRead(6'h10, 32'h0);
    idle(3);
    checkOutput("midRstNoDone", 32'(bus.bus_req), 32'd0);
    hpsRead(6'h02, 32'h0);

    idle(2);
    checkOutput("pendingReads", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
